// File: rtl/swd_xact_queue_if.sv
// Request/result channels between the command controller and swd_xact_queue.
// master = command controller side, slave = the queue engine.
interface swd_xact_queue_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_addr32;
  logic        req_rnw;
  logic        req_apndp;
  logic [31:0] req_wdata;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_ack;
  logic        res_perr;
  logic [31:0] res_rdata;
  logic [3:0]  res_retries;

  modport master (
    output req_valid, req_addr32, req_rnw, req_apndp, req_wdata, res_ready,
    input  req_ready, res_valid, res_ack, res_perr, res_rdata, res_retries
  );

  modport slave (
    input  req_valid, req_addr32, req_rnw, req_apndp, req_wdata, res_ready,
    output req_ready, res_valid, res_ack, res_perr, res_rdata, res_retries
  );
endinterface

// File: rtl/swd_xact_queue.sv
// swd_xact_queue: queued SWD transaction sequencer in front of dbgIF.
// Requests are buffered in a FIFO, issued as go/done exchanges, WAIT acks are
// retried after a back-off gap, and one result per request is returned.
// Optional feature macro: SWD_XACT_FAULT_FLUSH_EN (flush queued requests on
// FAULT ack or parity error, each returning an ack-000 result).
module swd_xact_queue #(
  parameter int         QDEPTH_LOG2  = 2,
  parameter int         MAX_RETRY    = 15,
  parameter int         RETRY_GAP    = 8,
  parameter logic [3:0] CMD_TRANSACT = 4'd2
) (
  input  logic                  clk,
  input  logic                  rst,
  swd_xact_queue_if.slave       xq,
  input  logic                  abort,
  output logic                  busy,
  output logic                  fault_sticky,
  input  logic                  clr_fault,
  output logic [1:0]            addr32,
  output logic                  rnw,
  output logic                  apndp,
  output logic [31:0]           dwrite,
  output logic [3:0]            command,
  output logic                  go,
  input  logic                  done,
  input  logic                  perr,
  input  logic [2:0]            ack,
  input  logic [31:0]           dread
);
  localparam int DEPTH = 1 << QDEPTH_LOG2;
  localparam int GAPW  = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam logic [GAPW-1:0]        GAP_LAST    = GAPW'(RETRY_GAP - 1);
  localparam logic [3:0]             RETRY_LIMIT = 4'(MAX_RETRY);
  localparam logic [QDEPTH_LOG2:0]   FULL_CNT    = (QDEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RUN, S_EVAL, S_BACKOFF, S_PUSH} state_t;

  // FIFO entry layout: {addr32[1:0], rnw, apndp, wdata[31:0]}
  logic [35:0]            fifo_mem [DEPTH];
  logic [35:0]            head;
  logic [QDEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QDEPTH_LOG2:0]   count_q, count_d;
  logic                   full, push, pop, fault_set;

  state_t          state_q, state_d;
  logic [1:0]      addr_q, addr_d;
  logic            rnw_q, rnw_d, apndp_q, apndp_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      retry_q, retry_d;
  logic [GAPW-1:0] gap_q, gap_d;
  logic [2:0]      stg_ack_q, stg_ack_d;
  logic            stg_perr_q, stg_perr_d;
  logic [31:0]     stg_rdata_q, stg_rdata_d;
  logic            res_valid_q, res_valid_d;
  logic [2:0]      res_ack_q, res_ack_d;
  logic            res_perr_q, res_perr_d;
  logic [31:0]     res_rdata_q, res_rdata_d;
  logic [3:0]      res_retries_q, res_retries_d;
  logic            fault_q, fault_d;
`ifdef SWD_XACT_FAULT_FLUSH_EN
  logic [QDEPTH_LOG2:0] flush_left_q, flush_left_d;
`endif

  assign full = (count_q == FULL_CNT);
  assign push = xq.req_valid && !full && !abort;
  assign head = fifo_mem[rd_ptr_q];

  // Request storage; written only on an accepted request, never reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {xq.req_addr32, xq.req_rnw, xq.req_apndp, xq.req_wdata};
  end

  // Next-state logic for the FIFO pointers, transaction FSM and result buffer.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    addr_d        = addr_q;
    rnw_d         = rnw_q;
    apndp_d       = apndp_q;
    wdata_d       = wdata_q;
    retry_d       = retry_q;
    gap_d         = gap_q;
    stg_ack_d     = stg_ack_q;
    stg_perr_d    = stg_perr_q;
    stg_rdata_d   = stg_rdata_q;
    res_valid_d   = res_valid_q;
    res_ack_d     = res_ack_q;
    res_perr_d    = res_perr_q;
    res_rdata_d   = res_rdata_q;
    res_retries_d = res_retries_q;
    fault_d       = fault_q;
    pop           = 1'b0;
    fault_set     = 1'b0;
`ifdef SWD_XACT_FAULT_FLUSH_EN
    flush_left_d  = flush_left_q;
`endif

    // Consumer handshake frees the single result slot on the following edge.
    if (res_valid_q && xq.res_ready) res_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!abort && count_q != '0) begin
          pop     = 1'b1;
          retry_d = '0;
`ifdef SWD_XACT_FAULT_FLUSH_EN
          if (flush_left_q != '0) begin
            // Flushed request: no bus activity, straight to an ack-000 result.
            flush_left_d = flush_left_q - 1'b1;
            stg_ack_d    = 3'b000;
            stg_perr_d   = 1'b0;
            stg_rdata_d  = '0;
            state_d      = S_PUSH;
          end else begin
            {addr_d, rnw_d, apndp_d, wdata_d} = head;
            state_d = S_ISSUE;
          end
`else
          {addr_d, rnw_d, apndp_d, wdata_d} = head;
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: if (!done) state_d = S_RUN;
      S_RUN:   if (done) state_d = S_EVAL;
      S_EVAL: begin
        if (ack == 3'b100 || perr) fault_set = 1'b1;
        if (ack == ACK_WAIT && retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 1'b1;
          gap_d   = '0;
          state_d = S_BACKOFF;
        end else begin
          stg_ack_d   = ack;
          stg_perr_d  = perr;
          stg_rdata_d = rnw_q ? dread : 32'h0;
          state_d     = S_PUSH;
        end
      end
      S_BACKOFF: begin
        if (abort) begin
          // Aborted while waiting to retry: report the outstanding WAIT.
          stg_ack_d   = ACK_WAIT;
          stg_perr_d  = 1'b0;
          stg_rdata_d = '0;
          state_d     = S_PUSH;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_PUSH: begin
        if (!res_valid_q) begin
          res_valid_d   = 1'b1;
          res_ack_d     = stg_ack_q;
          res_perr_d    = stg_perr_q;
          res_rdata_d   = stg_rdata_q;
          res_retries_d = retry_q;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (abort) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

`ifdef SWD_XACT_FAULT_FLUSH_EN
    // Everything still queued after this edge is flushed.
    if (fault_set) flush_left_d = count_d;
    if (abort)     flush_left_d = '0;
`endif

    // A new fault wins over a simultaneous clear.
    if (clr_fault) fault_d = 1'b0;
    if (fault_set) fault_d = 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      addr_q        <= '0;
      rnw_q         <= 1'b0;
      apndp_q       <= 1'b0;
      wdata_q       <= '0;
      retry_q       <= '0;
      gap_q         <= '0;
      stg_ack_q     <= '0;
      stg_perr_q    <= 1'b0;
      stg_rdata_q   <= '0;
      res_valid_q   <= 1'b0;
      res_ack_q     <= '0;
      res_perr_q    <= 1'b0;
      res_rdata_q   <= '0;
      res_retries_q <= '0;
      fault_q       <= 1'b0;
`ifdef SWD_XACT_FAULT_FLUSH_EN
      flush_left_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      rnw_q         <= rnw_d;
      apndp_q       <= apndp_d;
      wdata_q       <= wdata_d;
      retry_q       <= retry_d;
      gap_q         <= gap_d;
      stg_ack_q     <= stg_ack_d;
      stg_perr_q    <= stg_perr_d;
      stg_rdata_q   <= stg_rdata_d;
      res_valid_q   <= res_valid_d;
      res_ack_q     <= res_ack_d;
      res_perr_q    <= res_perr_d;
      res_rdata_q   <= res_rdata_d;
      res_retries_q <= res_retries_d;
      fault_q       <= fault_d;
`ifdef SWD_XACT_FAULT_FLUSH_EN
      flush_left_q  <= flush_left_d;
`endif
    end
  end

  assign xq.req_ready   = !full;
  assign xq.res_valid   = res_valid_q;
  assign xq.res_ack     = res_ack_q;
  assign xq.res_perr    = res_perr_q;
  assign xq.res_rdata   = res_rdata_q;
  assign xq.res_retries = res_retries_q;
  assign busy           = (count_q != '0) || (state_q != S_IDLE);
  assign fault_sticky   = fault_q;
  assign go             = (state_q == S_ISSUE);
  assign command        = CMD_TRANSACT;
  assign addr32         = addr_q;
  assign rnw            = rnw_q;
  assign apndp          = apndp_q;
  assign dwrite         = wdata_q;
endmodule
